dcache_controller: RTL and testbench
====================================

# dcache_controller

Sequencing controller for the 2-way, 16-set, 256-bit-line data cache SRAM. It sits between the CPU load/store port, the SRAM and the off-chip data memory. It serves hits in zero extra cycles and stalls the CPU on a miss. On a miss it writes back a dirty LRU victim, refills the line from memory and writes the refilled tag/data into the SRAM. The CPU then replays its access, which now hits.

## Interface
- No parameters; geometry is fixed.
- Address map: offset [4:0] (word select [4:2]), index [8:5], tag [31:9].
- SRAM tag format: bit 24 valid, bit 23 dirty, [22:0] tag.

Ports:
- clk_i  in  1  clock; everything sampled on rising edge
- rst_i  in  1  reset, synchronous, active-high
- cpu_req_i  in  1  CPU access request; held stable until cpu_stall_o low
- cpu_write_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address (word-aligned)
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data, valid when cpu_req_i & ~cpu_write_i & ~cpu_stall_o
- cpu_stall_o  out  1  CPU must hold request
- sram_enable_o  out  1  to SRAM enable_i
- sram_write_o  out  1  to SRAM write_i
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  tag presented for lookup/write
- sram_data_o  out  256  line presented for write
- sram_tag_i  in  25  hit way tag on hit; LRU victim tag on miss
- sram_data_i  in  256  hit way line on hit; LRU victim line on miss
- sram_hit_i  in  1  SRAM hit
- mem_enable_o  out  1  one-cycle memory request pulse
- mem_write_o  out  1  1 = write-back, 0 = line read
- mem_addr_o  out  32  line address, [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse

## Operation
- States: IDLE, MISS, WRITEBACK, ALLOCATE, REFILL.
- IDLE:
  - sram_enable_o = cpu_req_i; sram_addr_o = index; sram_tag_o = {1'b1, 1'b0, tag}.
  - Read hit: cpu_data_o = sram_data_i word [4:2].
  - Write hit: sram_write_o = 1. sram_data_o = sram_data_i with the selected word replaced by cpu_data_i. sram_tag_o = {1, 1, tag}.
  - Miss (cpu_req_i & ~sram_hit_i): latch the victim tag/line and the request; go to MISS.
- MISS:
  - If victim valid & dirty (sram_tag_i[24] & [23] as latched), go to WRITEBACK.
  - Otherwise go to ALLOCATE.
- WRITEBACK:
  - First cycle: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line.
  - Wait for mem_ack_i, then go to ALLOCATE.
- ALLOCATE:
  - First cycle: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i, capture mem_data_i and go to REFILL.
- REFILL:
  - One cycle: sram_enable_o = 1, sram_write_o = 1.
  - sram_tag_o = {1, 0, req tag}; sram_data_o = refilled line (the SRAM fills its LRU way).
  - Go to IDLE; the replayed access hits there (a store hit then sets dirty).
- mem_addr_o/mem_data_o hold stable from the request pulse through the ack.
- mem_ack_i is ignored in IDLE, MISS and REFILL.

## Timing
- Reset: state = IDLE, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, latched registers = 0.
  - cpu_stall_o = 0 and sram_enable_o/sram_write_o = 0 while cpu_req_i = 0.
- cpu_stall_o = (IDLE & cpu_req_i & ~sram_hit_i) | (state != IDLE); it is combinational in IDLE.
- Hit latency: 0 stall cycles.
- Clean miss, memory ack N cycles after the pulse: IDLE, MISS, ALLOCATE (N+1 cycles), REFILL, IDLE. Stall lasts N+4 cycles including the detect cycle.
- Dirty miss: add a WRITEBACK phase of M+1 cycles.
- mem_ack_i in the same cycle as the request pulse (N = 0) is legal and accepted.
- Reset asserted in any state: IDLE next cycle. No SRAM write occurs in that cycle; outstanding memory transactions are abandoned.
- cpu_req_i dropping while stalled is a protocol violation; the controller completes the refill anyway.

## Test plan
- Reset, then load 0x0000_0040 to an empty cache -> stall for the clean miss. One read pulse at mem_addr_o 0x0000_0040, then a REFILL write with tag {1,0,23'h0}. The replay returns word 0 of mem_data_i with no writeback.
- Store 0xDEAD_BEEF to 0x0000_0044 after the fill -> no stall. SRAM write asserts with dirty = 1 and word 1 replaced.
- Fill both ways of set 2 with 0x0000_0040 (then dirtied) and 0x0000_0240, then load 0x0000_0440 -> WRITEBACK pulse to 0x0000_0040 carrying the dirty line, then ALLOCATE read pulse to 0x0000_0440.
- Clean-victim miss with mem_ack_i delayed by 0 and by 7 cycles -> stall lengths of exactly 4 and 11 cycles.
- Assert rst_i mid-ALLOCATE, then send a late mem_ack_i -> state IDLE, mem_enable_o = 0, no SRAM write, ack ignored.

Source files
------------

// File: rtl/dcache_controller_if.sv
// Signal bundle between the dcache controller, the CPU port, the cache SRAM and data memory.
// The slave modport is the controller's view; master is the surrounding environment.
interface dcache_controller_if;
   logic         cpu_req_i;
   logic         cpu_write_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;

   logic         sram_enable_o;
   logic         sram_write_o;
   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o;
   logic [255:0] sram_data_o;
   logic [24:0]  sram_tag_i;
   logic [255:0] sram_data_i;
   logic         sram_hit_i;

   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   modport slave (
      input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
      output cpu_data_o, cpu_stall_o,
      output sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
      input  sram_tag_i, sram_data_i, sram_hit_i,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i
   );

   modport master (
      output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
      input  cpu_data_o, cpu_stall_o,
      input  sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
      output sram_tag_i, sram_data_i, sram_hit_i,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i
   );
endinterface

// File: rtl/dcache_controller.sv
// Sequencing controller for a 2-way, 16-set, 256-bit-line data cache: zero-stall hits,
// dirty-victim write-back, line refill, then CPU replay.
module dcache_controller (
   input  logic                clk_i,
   input  logic                rst_i,
   dcache_controller_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      ALLOCATE,
      REFILL
   } state_t;

   state_t        r_state;
   state_t        w_next;

   logic [24:0]   r_victim_tag;
   logic [255:0]  r_victim_data;
   logic [26:0]   r_req_line;
   logic [255:0]  r_refill_data;
   logic          r_mem_enable;
   logic          r_mem_write;
   logic [31:0]   r_mem_addr;
   logic [255:0]  r_mem_data;

   logic [2:0]    w_word;
   logic [3:0]    w_index;
   logic [22:0]   w_tag;
   logic          w_miss;
   logic          w_victim_dirty;
   logic [255:0]  w_merged;

   assign w_word         = bus.cpu_addr_i[4:2];
   assign w_index        = bus.cpu_addr_i[8:5];
   assign w_tag          = bus.cpu_addr_i[31:9];
   assign w_miss         = (r_state == IDLE) & bus.cpu_req_i & ~bus.sram_hit_i;
   assign w_victim_dirty = r_victim_tag[24] & r_victim_tag[23];

   always_comb begin
      w_merged = bus.sram_data_i;
      w_merged[{w_word, 5'b0} +: 32] = bus.cpu_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_miss) w_next = MISS;
         MISS:      w_next = w_victim_dirty ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (bus.mem_ack_i) w_next = ALLOCATE;
         ALLOCATE:  if (bus.mem_ack_i) w_next = REFILL;
         REFILL:    w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // Memory request registers: the enable is a one-cycle pulse raised on entry to
   // WRITEBACK/ALLOCATE, while address/data stay put until the next request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_victim_tag  <= '0;
         r_victim_data <= '0;
         r_req_line    <= '0;
         r_refill_data <= '0;
         r_mem_enable  <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_data    <= '0;
      end else begin
         r_mem_enable <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_miss) begin
                  r_victim_tag  <= bus.sram_tag_i;
                  r_victim_data <= bus.sram_data_i;
                  r_req_line    <= bus.cpu_addr_i[31:5];
               end
            end
            MISS: begin
               r_mem_enable <= 1'b1;
               if (w_victim_dirty) begin
                  r_mem_write <= 1'b1;
                  r_mem_addr  <= {r_victim_tag[22:0], r_req_line[3:0], 5'b0};
                  r_mem_data  <= r_victim_data;
               end else begin
                  r_mem_write <= 1'b0;
                  r_mem_addr  <= {r_req_line, 5'b0};
               end
            end
            WRITEBACK: begin
               if (bus.mem_ack_i) begin
                  r_mem_enable <= 1'b1;
                  r_mem_write  <= 1'b0;
                  r_mem_addr   <= {r_req_line, 5'b0};
               end
            end
            ALLOCATE: begin
               if (bus.mem_ack_i) begin
                  r_refill_data <= bus.mem_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.cpu_stall_o   = 1'b1;
      bus.cpu_data_o    = bus.sram_data_i[{w_word, 5'b0} +: 32];
      bus.sram_enable_o = 1'b0;
      bus.sram_write_o  = 1'b0;
      bus.sram_addr_o   = r_req_line[3:0];
      bus.sram_tag_o    = {1'b1, 1'b0, r_req_line[26:4]};
      bus.sram_data_o   = r_refill_data;
      case (r_state)
         IDLE: begin
            bus.cpu_stall_o   = w_miss;
            bus.sram_enable_o = bus.cpu_req_i;
            bus.sram_addr_o   = w_index;
            bus.sram_tag_o    = {1'b1, 1'b0, w_tag};
            bus.sram_data_o   = w_merged;
            if (bus.cpu_req_i & bus.cpu_write_i & bus.sram_hit_i) begin
               bus.sram_write_o = 1'b1;
               bus.sram_tag_o   = {1'b1, 1'b1, w_tag};
            end
         end
         REFILL: begin
            bus.sram_enable_o = 1'b1;
            bus.sram_write_o  = 1'b1;
         end
         default: ;
      endcase
      // A reset cycle must never commit an SRAM write, whatever state it lands in.
      if (rst_i) begin
         bus.sram_write_o = 1'b0;
      end
   end

   assign bus.mem_enable_o = r_mem_enable & ~rst_i;
   assign bus.mem_write_o  = r_mem_write;
   assign bus.mem_addr_o   = r_mem_addr;
   assign bus.mem_data_o   = r_mem_data;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller: reset, hits, clean/dirty misses,
// ack latency and reset during an outstanding refill.
module tb_dcache_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dcache_controller_if bus();

   dcache_controller dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   int n_pass  = 0;
   int n_total = 0;

   int            ack_delay   = 2;
   logic          mem_auto    = 1'b1;
   logic          manual_ack  = 1'b0;
   logic [255:0]  refill_line = '0;
   logic          pend        = 1'b0;
   int            cnt         = 0;
   logic          hold_err    = 1'b0;
   logic [31:0]   held_addr;
   logic [255:0]  held_data;

   logic          mreq_wr[$];
   logic [31:0]   mreq_addr[$];
   logic [255:0]  mreq_data[$];
   logic [3:0]    swr_addr[$];
   logic [24:0]   swr_tag[$];
   logic [255:0]  swr_data[$];

   logic [255:0]  line1, line2, line3;

   // Memory responder and SRAM write recorder, sampling on the falling edge.
   always @(negedge clk) begin
      bus.mem_ack_i  = manual_ack;
      bus.mem_data_i = refill_line;
      if (rst) pend = 1'b0;
      if (pend) begin
         if (bus.mem_addr_o !== held_addr || bus.mem_data_o !== held_data) hold_err = 1'b1;
         if (cnt == 0) begin
            bus.mem_ack_i = 1'b1;
            pend = 1'b0;
         end else begin
            cnt--;
         end
      end
      if (bus.mem_enable_o && mem_auto) begin
         mreq_wr.push_back(bus.mem_write_o);
         mreq_addr.push_back(bus.mem_addr_o);
         mreq_data.push_back(bus.mem_data_o);
         held_addr = bus.mem_addr_o;
         held_data = bus.mem_data_o;
         if (ack_delay == 0) begin
            bus.mem_ack_i = 1'b1;
         end else begin
            pend = 1'b1;
            cnt  = ack_delay - 1;
         end
      end
      if (bus.sram_enable_o && bus.sram_write_o) begin
         swr_addr.push_back(bus.sram_addr_o);
         swr_tag.push_back(bus.sram_tag_o);
         swr_data.push_back(bus.sram_data_o);
      end
   end

   task automatic clear_logs();
      mreq_wr = {}; mreq_addr = {}; mreq_data = {};
      swr_addr = {}; swr_tag = {}; swr_data = {};
      hold_err = 1'b0;
   endtask

   // Issue an access and hold it until the stall drops; the SRAM stand-in starts
   // hitting on the refilled line once the refill write is seen.
   task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic hit, input logic [24:0] tag, input logic [255:0] line,
                            output int stall_n, output logic [24:0] first_tag);
      @(posedge clk); #2;
      bus.cpu_req_i   = 1'b1;
      bus.cpu_write_i = wr;
      bus.cpu_addr_i  = addr;
      bus.cpu_data_i  = wdata;
      bus.sram_hit_i  = hit;
      bus.sram_tag_i  = tag;
      bus.sram_data_i = line;
      stall_n   = 0;
      first_tag = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 0) first_tag = bus.sram_tag_o;
         if (bus.sram_enable_o && bus.sram_write_o && bus.cpu_stall_o) begin
            bus.sram_hit_i  = 1'b1;
            bus.sram_tag_i  = bus.sram_tag_o;
            bus.sram_data_i = bus.sram_data_o;
         end
         if (!bus.cpu_stall_o) break;
         stall_n++;
      end
   endtask

   task automatic end_access();
      @(posedge clk); #2;
      bus.cpu_req_i   = 1'b0;
      bus.cpu_write_i = 1'b0;
      bus.sram_hit_i  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cpu_req_i = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      n_total++; if (bus.cpu_stall_o !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.cpu_stall_o); else n_pass++;
      n_total++; if (bus.sram_enable_o !== 1'b0) $display("FAIL reset_sram_en got %b want 0", bus.sram_enable_o); else n_pass++;
      n_total++; if (bus.sram_write_o !== 1'b0) $display("FAIL reset_sram_wr got %b want 0", bus.sram_write_o); else n_pass++;
      n_total++; if (bus.mem_enable_o !== 1'b0) $display("FAIL reset_mem_en got %b want 0", bus.mem_enable_o); else n_pass++;
      n_total++; if (bus.mem_write_o !== 1'b0) $display("FAIL reset_mem_wr got %b want 0", bus.mem_write_o); else n_pass++;
      n_total++; if (bus.mem_addr_o !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr_o); else n_pass++;
      n_total++; if (bus.mem_data_o !== 256'h0) $display("FAIL reset_mem_data got %h want 0", bus.mem_data_o); else n_pass++;
   endtask

   task automatic test_clean_miss();
      int s;
      logic [24:0] ft;
      clear_logs();
      ack_delay   = 2;
      refill_line = line1;
      do_access(1'b0, 32'h0000_0040, 32'h0, 1'b0, 25'h0, line3, s, ft);
      n_total++; if (ft !== 25'h100_0000) $display("FAIL miss_lookup_tag got %h want 1000000", ft); else n_pass++;
      n_total++; if (s != 6) $display("FAIL miss_stall_len got %0d want 6", s); else n_pass++;
      n_total++; if (bus.cpu_data_o !== 32'h1000_0000) $display("FAIL miss_replay_data got %h want 10000000", bus.cpu_data_o); else n_pass++;
      n_total++; if (mreq_wr.size() != 1) $display("FAIL miss_mem_reqs got %0d want 1", mreq_wr.size()); else n_pass++;
      n_total++; if (mreq_wr[0] !== 1'b0) $display("FAIL miss_mem_wr got %b want 0", mreq_wr[0]); else n_pass++;
      n_total++; if (mreq_addr[0] !== 32'h0000_0040) $display("FAIL miss_mem_addr got %h want 00000040", mreq_addr[0]); else n_pass++;
      n_total++; if (swr_tag.size() != 1) $display("FAIL miss_sram_writes got %0d want 1", swr_tag.size()); else n_pass++;
      n_total++; if (swr_tag[0] !== 25'h100_0000) $display("FAIL miss_refill_tag got %h want 1000000", swr_tag[0]); else n_pass++;
      n_total++; if (swr_addr[0] !== 4'd2) $display("FAIL miss_refill_set got %0d want 2", swr_addr[0]); else n_pass++;
      n_total++; if (swr_data[0] !== line1) $display("FAIL miss_refill_data got %h want %h", swr_data[0], line1); else n_pass++;
      end_access();
   endtask

   task automatic test_hits();
      int s;
      logic [24:0] ft;
      logic [255:0] exp_line;
      exp_line = line1;
      exp_line[63:32] = 32'hDEAD_BEEF;
      do_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b1, 25'h100_0000, line1, s, ft);
      n_total++; if (s != 0) $display("FAIL store_hit_stall got %0d want 0", s); else n_pass++;
      n_total++; if (bus.sram_write_o !== 1'b1) $display("FAIL store_hit_wr got %b want 1", bus.sram_write_o); else n_pass++;
      n_total++; if (bus.sram_tag_o !== 25'h180_0000) $display("FAIL store_hit_tag got %h want 1800000", bus.sram_tag_o); else n_pass++;
      n_total++; if (bus.sram_data_o !== exp_line) $display("FAIL store_hit_data got %h want %h", bus.sram_data_o, exp_line); else n_pass++;
      end_access();
      do_access(1'b0, 32'h0000_005C, 32'h0, 1'b1, 25'h100_0000, line1, s, ft);
      n_total++; if (s != 0) $display("FAIL load_hit_stall got %0d want 0", s); else n_pass++;
      n_total++; if (bus.cpu_data_o !== 32'h1000_0007) $display("FAIL load_hit_word7 got %h want 10000007", bus.cpu_data_o); else n_pass++;
      n_total++; if (bus.sram_write_o !== 1'b0) $display("FAIL load_hit_wr got %b want 0", bus.sram_write_o); else n_pass++;
      end_access();
   endtask

   task automatic test_dirty_writeback();
      int s;
      logic [24:0] ft;
      logic [255:0] dirty_line;
      dirty_line = line1;
      dirty_line[63:32] = 32'hDEAD_BEEF;
      clear_logs();
      ack_delay   = 1;
      refill_line = line3;
      do_access(1'b0, 32'h0000_0240, 32'h0, 1'b0, 25'h0, line3, s, ft);
      n_total++; if (swr_tag[0] !== 25'h100_0001) $display("FAIL fill240_tag got %h want 1000001", swr_tag[0]); else n_pass++;
      end_access();
      clear_logs();
      ack_delay   = 3;
      refill_line = line2;
      do_access(1'b0, 32'h0000_0440, 32'h0, 1'b0, 25'h180_0000, dirty_line, s, ft);
      n_total++; if (s != 11) $display("FAIL dirty_stall_len got %0d want 11", s); else n_pass++;
      n_total++; if (mreq_wr.size() != 2) $display("FAIL dirty_mem_reqs got %0d want 2", mreq_wr.size()); else n_pass++;
      n_total++; if (mreq_wr[0] !== 1'b1) $display("FAIL wb_mem_wr got %b want 1", mreq_wr[0]); else n_pass++;
      n_total++; if (mreq_addr[0] !== 32'h0000_0040) $display("FAIL wb_mem_addr got %h want 00000040", mreq_addr[0]); else n_pass++;
      n_total++; if (mreq_data[0] !== dirty_line) $display("FAIL wb_mem_data got %h want %h", mreq_data[0], dirty_line); else n_pass++;
      n_total++; if (mreq_wr[1] !== 1'b0) $display("FAIL alloc_mem_wr got %b want 0", mreq_wr[1]); else n_pass++;
      n_total++; if (mreq_addr[1] !== 32'h0000_0440) $display("FAIL alloc_mem_addr got %h want 00000440", mreq_addr[1]); else n_pass++;
      n_total++; if (hold_err !== 1'b0) $display("FAIL mem_hold_stable got %b want 0", hold_err); else n_pass++;
      n_total++; if (swr_tag[0] !== 25'h100_0002) $display("FAIL dirty_refill_tag got %h want 1000002", swr_tag[0]); else n_pass++;
      n_total++; if (bus.cpu_data_o !== 32'h2000_0000) $display("FAIL dirty_replay_data got %h want 20000000", bus.cpu_data_o); else n_pass++;
      end_access();
   endtask

   task automatic test_ack_latency();
      int s;
      logic [24:0] ft;
      clear_logs();
      ack_delay   = 0;
      refill_line = line3;
      do_access(1'b0, 32'h0000_0060, 32'h0, 1'b0, 25'h100_0005, line1, s, ft);
      n_total++; if (s != 4) $display("FAIL ack0_stall_len got %0d want 4", s); else n_pass++;
      n_total++; if (mreq_wr.size() != 1) $display("FAIL ack0_mem_reqs got %0d want 1", mreq_wr.size()); else n_pass++;
      end_access();
      clear_logs();
      ack_delay = 7;
      do_access(1'b0, 32'h0000_0260, 32'h0, 1'b0, 25'h100_0005, line1, s, ft);
      n_total++; if (s != 11) $display("FAIL ack7_stall_len got %0d want 11", s); else n_pass++;
      n_total++; if (mreq_wr[0] !== 1'b0) $display("FAIL ack7_clean_victim_wr got %b want 0", mreq_wr[0]); else n_pass++;
      n_total++; if (hold_err !== 1'b0) $display("FAIL ack7_hold_stable got %b want 0", hold_err); else n_pass++;
      end_access();
   endtask

   task automatic test_reset_mid_alloc();
      mem_auto = 1'b0;
      @(posedge clk); #2;
      bus.cpu_req_i   = 1'b1;
      bus.cpu_write_i = 1'b0;
      bus.cpu_addr_i  = 32'h0000_00A0;
      bus.sram_hit_i  = 1'b0;
      bus.sram_tag_i  = 25'h0;
      @(negedge clk);
      n_total++; if (bus.cpu_stall_o !== 1'b1) $display("FAIL rsta_detect_stall got %b want 1", bus.cpu_stall_o); else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++; if (bus.mem_enable_o !== 1'b1) $display("FAIL rsta_alloc_pulse got %b want 1", bus.mem_enable_o); else n_pass++;
      n_total++; if (bus.mem_addr_o !== 32'h0000_00A0) $display("FAIL rsta_alloc_addr got %h want 000000a0", bus.mem_addr_o); else n_pass++;
      @(posedge clk); #2;
      rst = 1'b1;
      bus.cpu_req_i = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      manual_ack = 1'b1;
      @(negedge clk);
      n_total++; if (bus.cpu_stall_o !== 1'b0) $display("FAIL rsta_idle_stall got %b want 0", bus.cpu_stall_o); else n_pass++;
      n_total++; if (bus.mem_enable_o !== 1'b0) $display("FAIL rsta_mem_en got %b want 0", bus.mem_enable_o); else n_pass++;
      n_total++; if (bus.mem_addr_o !== 32'h0) $display("FAIL rsta_mem_addr got %h want 0", bus.mem_addr_o); else n_pass++;
      @(posedge clk); #2;
      manual_ack = 1'b0;
      @(negedge clk);
      n_total++; if (bus.cpu_stall_o !== 1'b0) $display("FAIL late_ack_stall got %b want 0", bus.cpu_stall_o); else n_pass++;
      n_total++; if (bus.sram_write_o !== 1'b0) $display("FAIL late_ack_sram_wr got %b want 0", bus.sram_write_o); else n_pass++;
      n_total++; if (bus.sram_enable_o !== 1'b0) $display("FAIL late_ack_sram_en got %b want 0", bus.sram_enable_o); else n_pass++;
      @(posedge clk); #2;
      bus.cpu_req_i   = 1'b1;
      bus.sram_hit_i  = 1'b1;
      bus.sram_tag_i  = 25'h100_0000;
      bus.sram_data_i = line1;
      @(negedge clk);
      n_total++; if (bus.cpu_stall_o !== 1'b0) $display("FAIL late_ack_hit_stall got %b want 0", bus.cpu_stall_o); else n_pass++;
      n_total++; if (bus.cpu_data_o !== 32'h1000_0000) $display("FAIL late_ack_hit_data got %h want 10000000", bus.cpu_data_o); else n_pass++;
      end_access();
      mem_auto = 1'b1;
   endtask

   task automatic test_reset_in_refill();
      ack_delay = 0;
      @(posedge clk); #2;
      bus.cpu_req_i   = 1'b1;
      bus.cpu_write_i = 1'b0;
      bus.cpu_addr_i  = 32'h0000_00C0;
      bus.sram_hit_i  = 1'b0;
      bus.sram_tag_i  = 25'h0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      bus.cpu_req_i = 1'b0;
      @(negedge clk);
      n_total++; if (bus.sram_write_o !== 1'b0) $display("FAIL refill_rst_sram_wr got %b want 0", bus.sram_write_o); else n_pass++;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      n_total++; if (bus.cpu_stall_o !== 1'b0) $display("FAIL refill_rst_idle got %b want 0", bus.cpu_stall_o); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 8; i++) begin
         line1[i*32 +: 32] = 32'h1000_0000 + i;
         line2[i*32 +: 32] = 32'h2000_0000 + 16 * i;
         line3[i*32 +: 32] = 32'h3300_0000 + i;
      end
      bus.cpu_req_i   = 1'b0;
      bus.cpu_write_i = 1'b0;
      bus.cpu_addr_i  = 32'h0;
      bus.cpu_data_i  = 32'h0;
      bus.sram_tag_i  = 25'h0;
      bus.sram_data_i = '0;
      bus.sram_hit_i  = 1'b0;
      test_reset();
      test_clean_miss();
      test_hits();
      test_dirty_writeback();
      test_ack_latency();
      test_reset_mid_alloc();
      test_reset_in_refill();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
